dma_xfer_sequencer: RTL

Parametrised successor of the DMA timing-control block. It arbitrates among `NUM_CH` request channels and owns the per-channel current/base address and word counters. It sequences the SI/S0–S4 bus cycle, driving `HRQ`, `DACK`, `AEN`, `ADSTB`, the strobes and the terminal-count `EOP`. It supports single, block and demand service, address increment/decrement, autoinitialize and extended write, and sits between the register file and the system bus pins.

---
 rtl/dma_xfer_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_xfer_sequencer.sv
// dma_xfer_sequencer: NUM_CH-channel DMA arbiter, per-channel address/count owner, SI/S0-S4 bus cycle sequencer.
// Latency: valid DREQ->HRQ 1 clk, HLDA->DACK 1 clk, 4 clks per word (S1..S4); every output is a flop.
// Backpressure: the CPU gates the bus via HLDA; S0 waits for it, HLDA low in S1-S3 aborts the word.
// Build option: define DMA_ROT_PRIO_EN for rotating priority; otherwise fixed priority, channel 0 highest.
// PROG_DATA must be at least 8 bits wide (mode lives in bits [7:0]).
module dma_xfer_sequencer #(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 16,
  parameter  int CNT_W  = 16,
  localparam int DATA_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic              EOP_N_IN,
  input  logic              PROG_WE,
  input  logic [2:0]        PROG_CH,
  input  logic [1:0]        PROG_SEL,
  input  logic [DATA_W-1:0] PROG_DATA,
  input  logic              EXT_WRITE,
  input  logic              STATUS_RD,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              AEN,
  output logic              ADSTB,
  output logic [ADDR_W-1:0] ADDR,
  output logic              IOR_N,
  output logic              IOW_N,
  output logic              MEMR_N,
  output logic              MEMW_N,
  output logic              EOP_N_OUT,
  output logic              EOP_OE,
  output logic [NUM_CH-1:0] TC_STATUS
);

  typedef enum logic [5:0] {
    ST_SI = 6'b000001,
    ST_S0 = 6'b000010,
    ST_S1 = 6'b000100,
    ST_S2 = 6'b001000,
    ST_S3 = 6'b010000,
    ST_S4 = 6'b100000
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic [ADDR_W-1:0]   base_addr [NUM_CH];
  logic [ADDR_W-1:0]   cur_addr  [NUM_CH];
  logic [CNT_W-1:0]    base_cnt  [NUM_CH];
  logic [CNT_W-1:0]    cur_cnt   [NUM_CH];
  // Mode bits [7:2] of the programmed byte: {service[1:0], decrement, autoinit, type[1:0]}
  logic [5:0]          mode      [NUM_CH];
  logic [NUM_CH-1:0]   mask;
  logic                ext_eop;   // external EOP seen earlier in this word
  logic                tc_hit;    // current S4 is a terminal-count cycle

  logic [NUM_CH-1:0]   req_vld;
  logic                any_req;
  logic [CH_W-1:0]     win;
  logic [NUM_CH-1:0]   ch_onehot;
  logic [1:0]          svc;
  logic                dec, autoi, is_wr, is_rd;
  logic                abort, tc_now, s3_done, cont, prog_ok;

  assign req_vld   = DREQ & ~mask;
  assign any_req   = |req_vld;
  assign ch_onehot = NUM_CH'(1) << ch;
  assign svc       = mode[ch][5:4];
  assign dec       = mode[ch][3];
  assign autoi     = mode[ch][2];
  assign is_wr     = (mode[ch][1:0] == 2'b01);
  assign is_rd     = (mode[ch][1:0] == 2'b10);
  assign abort     = ~HLDA & ((state == ST_S1) | (state == ST_S2) | (state == ST_S3));
  assign s3_done   = (state == ST_S3) & HLDA;
  // Count of zero on entry to S4, or EOP_N_IN low anywhere in S1-S3, ends the service
  assign tc_now    = (cur_cnt[ch] == '0) | ext_eop | ~EOP_N_IN;
  // Keep servicing without going back through SI: block always, demand while DREQ holds
  assign cont      = ~tc_hit & ((svc == 2'b10) | ((svc == 2'b00) & DREQ[ch]));
  assign prog_ok   = PROG_WE & (int'(PROG_CH) < NUM_CH);

`ifdef DMA_ROT_PRIO_EN
  logic [CH_W-1:0] rot;
  logic            found;
  int              idx;

  // Rotating arbiter: scan upward from the rotation pointer, first valid request wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rot) + k) % NUM_CH;
      if (!found && req_vld[idx]) begin
        win   = CH_W'(idx);
        found = 1'b1;
      end
    end
  end

  // Rotation pointer: the channel after the one just served becomes highest priority
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rot <= '0;
    end else if (state == ST_S4) begin
      rot <= (int'(ch) == NUM_CH - 1) ? '0 : ch + CH_W'(1);
    end
  end
`else
  // Fixed arbiter: lowest-index valid request wins
  always_comb begin
    win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_vld[k]) win = CH_W'(k);
    end
  end
`endif

  // Main sequencer: state, channel registers and all registered bus outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_SI;
      ch        <= '0;
      mask      <= '1;
      ext_eop   <= 1'b0;
      tc_hit    <= 1'b0;
      HRQ       <= 1'b0;
      DACK      <= '0;
      AEN       <= 1'b0;
      ADSTB     <= 1'b0;
      ADDR      <= '0;
      IOR_N     <= 1'b1;
      IOW_N     <= 1'b1;
      MEMR_N    <= 1'b1;
      MEMW_N    <= 1'b1;
      EOP_N_OUT <= 1'b1;
      EOP_OE    <= 1'b0;
      TC_STATUS <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr[i] <= '0;
        cur_addr[i]  <= '0;
        base_cnt[i]  <= '0;
        cur_cnt[i]   <= '0;
        mode[i]      <= '0;
      end
    end else begin
      // TC pulse is exactly the S4 cycle of a terminating word
      EOP_N_OUT <= ~(s3_done & tc_now);
      EOP_OE    <= s3_done & tc_now;
      ext_eop   <= ~abort & ((state == ST_S1) | (state == ST_S2)) & (ext_eop | ~EOP_N_IN);
      // Status read clears first so a TC landing on the same edge still sets its bit
      if (STATUS_RD) TC_STATUS <= '0;

      if (abort || (state == ST_S4 && !cont)) begin
        state  <= ST_SI;
        HRQ    <= 1'b0;
        DACK   <= '0;
        AEN    <= 1'b0;
        ADSTB  <= 1'b0;
        ADDR   <= '0;
        IOR_N  <= 1'b1;
        IOW_N  <= 1'b1;
        MEMR_N <= 1'b1;
        MEMW_N <= 1'b1;
      end else begin
        case (state)
          ST_SI: begin
            if (prog_ok) begin
              case (PROG_SEL)
                2'b00: begin
                  base_addr[PROG_CH[CH_W-1:0]] <= PROG_DATA[ADDR_W-1:0];
                  cur_addr[PROG_CH[CH_W-1:0]]  <= PROG_DATA[ADDR_W-1:0];
                end
                2'b01: begin
                  base_cnt[PROG_CH[CH_W-1:0]] <= PROG_DATA[CNT_W-1:0];
                  cur_cnt[PROG_CH[CH_W-1:0]]  <= PROG_DATA[CNT_W-1:0];
                end
                2'b10:   mode[PROG_CH[CH_W-1:0]] <= PROG_DATA[7:2];
                default: mask[PROG_CH[CH_W-1:0]] <= PROG_DATA[0];
              endcase
            end
            if (any_req) begin
              ch    <= win;
              state <= ST_S0;
              HRQ   <= 1'b1;
            end
          end
          ST_S0: begin
            if (HLDA) begin
              state <= ST_S1;
              AEN   <= 1'b1;
              ADSTB <= 1'b1;
              DACK  <= ch_onehot;
              ADDR  <= cur_addr[ch];
            end
          end
          ST_S1: begin
            // Read side of the transfer first; extended write pulls the write strobe early
            state  <= ST_S2;
            ADSTB  <= 1'b0;
            IOR_N  <= ~is_wr;
            MEMR_N <= ~is_rd;
            MEMW_N <= ~(is_wr & EXT_WRITE);
            IOW_N  <= ~(is_rd & EXT_WRITE);
          end
          ST_S2: begin
            state  <= ST_S3;
            IOR_N  <= ~is_wr;
            MEMW_N <= ~is_wr;
            MEMR_N <= ~is_rd;
            IOW_N  <= ~is_rd;
          end
          ST_S3: begin
            state  <= ST_S4;
            IOR_N  <= 1'b1;
            IOW_N  <= 1'b1;
            MEMR_N <= 1'b1;
            MEMW_N <= 1'b1;
            tc_hit <= tc_now;
            if (tc_now) TC_STATUS[ch] <= 1'b1;
            if (tc_now && autoi) begin
              cur_addr[ch] <= base_addr[ch];
              cur_cnt[ch]  <= base_cnt[ch];
            end else begin
              cur_addr[ch] <= dec ? cur_addr[ch] - ADDR_W'(1) : cur_addr[ch] + ADDR_W'(1);
              cur_cnt[ch]  <= cur_cnt[ch] - CNT_W'(1);
              if (tc_now) mask[ch] <= 1'b1;
            end
          end
          ST_S4: begin
            // Only the continue path reaches here; next word starts with a fresh address strobe
            state <= ST_S1;
            ADSTB <= 1'b1;
            ADDR  <= cur_addr[ch];
          end
          default: state <= ST_SI;
        endcase
      end
    end
  end

endmodule
